text_console_writer: RTL and testbench

//  Writer side of the 80x34 text-mode character buffer that the VGA text renderer reads.

---
 rtl/text_console_writer.sv | 192 +++++++++++++++++++
 tb/tb_text_console_writer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/text_console_writer.sv
// Writer side of the 80x34 text-mode character buffer: turns an ASCII byte stream into
// character-RAM writes. Optional macro LINE_CLEAR_EN blanks each new row on a row advance.
module text_console_writer (
  input  logic        clk25mhz,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_emph,
  output logic        in_ready,
  output logic        wr_en,
  output logic [11:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic [11:0] cursor_addr,
  output logic        busy
);

  localparam logic [6:0]  COLS      = 7'd80;
  localparam logic [6:0]  COL_LAST  = 7'd79;
  localparam logic [5:0]  ROW_LAST  = 6'd33;
  localparam logic [11:0] CELL_LAST = 12'd2719;
  localparam logic [7:0]  BLANK     = 8'h20;

`ifdef LINE_CLEAR_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SCLR = 2'd1, LCLR = 2'd2} state_t;
  logic [6:0]  clr_cnt_r, clr_cnt_nx;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SCLR = 2'd1} state_t;
`endif

  state_t      state_r, state_nx;
  logic [6:0]  col_r, col_nx;
  logic [5:0]  row_r, row_nx;
  logic [11:0] cur_r, cur_nx;
  logic [11:0] clr_addr_r, clr_addr_nx;
  logic        wr_en_nx;
  logic [11:0] wr_addr_nx;
  logic [7:0]  wr_data_nx;
  logic [6:0]  tab_col;
  logic        accept;
  logic        advance;

  assign in_ready    = (state_r == IDLE);
  assign busy        = (state_r != IDLE);
  assign cursor_addr = cur_r;
  assign accept      = in_valid && in_ready;
  // Next multiple of 8 above col; col <= 79 keeps the upper nibble within 4 bits.
  assign tab_col     = {col_r[6:3] + 4'd1, 3'b000};

  // Byte decode, clear sequencing and next cursor/write values.
  always_comb begin
    state_nx    = state_r;
    col_nx      = col_r;
    row_nx      = row_r;
    cur_nx      = cur_r;
    clr_addr_nx = clr_addr_r;
    wr_en_nx    = 1'b0;
    wr_addr_nx  = wr_addr;
    wr_data_nx  = wr_data;
    advance     = 1'b0;
`ifdef LINE_CLEAR_EN
    clr_cnt_nx  = clr_cnt_r;
`endif
    case (state_r)
      IDLE: begin
        if (!accept) begin
          advance = 1'b0;
        end else if (in_data >= 8'h20 && in_data <= 8'h7E) begin
          wr_en_nx   = 1'b1;
          wr_addr_nx = cur_r;
          wr_data_nx = {in_emph, in_data[6:0]};
          if (col_r == COL_LAST) begin
            advance = 1'b1;
          end else begin
            col_nx = col_r + 7'd1;
            cur_nx = cur_r + 12'd1;
          end
        end else begin
          case (in_data)
            8'h0A: advance = 1'b1;
            8'h0D: begin
              col_nx = 7'd0;
              cur_nx = cur_r - {5'd0, col_r};
            end
            8'h08: begin
              if (col_r != 7'd0) begin
                col_nx     = col_r - 7'd1;
                cur_nx     = cur_r - 12'd1;
                wr_en_nx   = 1'b1;
                wr_addr_nx = cur_r - 12'd1;
                wr_data_nx = BLANK;
              end else begin
                col_nx = col_r;
              end
            end
            8'h09: begin
              if (tab_col > COL_LAST) begin
                advance = 1'b1;
              end else begin
                col_nx = tab_col;
                cur_nx = cur_r + {5'd0, 7'(tab_col - col_r)};
              end
            end
            8'h0C: begin
              col_nx      = 7'd0;
              row_nx      = 6'd0;
              cur_nx      = 12'd0;
              clr_addr_nx = 12'd0;
              state_nx    = SCLR;
            end
            default: advance = 1'b0;
          endcase
        end
        if (advance) begin
          col_nx = 7'd0;
          if (row_r == ROW_LAST) begin
            row_nx = 6'd0;
            cur_nx = 12'd0;
          end else begin
            row_nx = row_r + 6'd1;
            cur_nx = cur_r - {5'd0, col_r} + {5'd0, COLS};
          end
`ifdef LINE_CLEAR_EN
          clr_addr_nx = cur_nx;
          clr_cnt_nx  = 7'd0;
          state_nx    = LCLR;
`endif
        end else begin
          advance = 1'b0;
        end
      end
      SCLR: begin
        wr_en_nx   = 1'b1;
        wr_addr_nx = clr_addr_r;
        wr_data_nx = BLANK;
        if (clr_addr_r == CELL_LAST) begin
          clr_addr_nx = 12'd0;
          state_nx    = IDLE;
        end else begin
          clr_addr_nx = clr_addr_r + 12'd1;
        end
      end
`ifdef LINE_CLEAR_EN
      LCLR: begin
        wr_en_nx    = 1'b1;
        wr_addr_nx  = clr_addr_r;
        wr_data_nx  = BLANK;
        clr_addr_nx = clr_addr_r + 12'd1;
        clr_cnt_nx  = clr_cnt_r + 7'd1;
        if (clr_cnt_r == COL_LAST) begin
          state_nx = IDLE;
        end else begin
          state_nx = LCLR;
        end
      end
`endif
      default: begin
        clr_addr_nx = 12'd0;
        state_nx    = SCLR;
      end
    endcase
  end

  // State, cursor and registered write-port outputs.
  always_ff @(posedge clk25mhz) begin
    if (reset) begin
      state_r    <= SCLR;
      col_r      <= 7'd0;
      row_r      <= 6'd0;
      cur_r      <= 12'd0;
      clr_addr_r <= 12'd0;
      wr_en      <= 1'b0;
      wr_addr    <= 12'd0;
      wr_data    <= BLANK;
`ifdef LINE_CLEAR_EN
      clr_cnt_r  <= 7'd0;
`endif
    end else begin
      state_r    <= state_nx;
      col_r      <= col_nx;
      row_r      <= row_nx;
      cur_r      <= cur_nx;
      clr_addr_r <= clr_addr_nx;
      wr_en      <= wr_en_nx;
      wr_addr    <= wr_addr_nx;
      wr_data    <= wr_data_nx;
`ifdef LINE_CLEAR_EN
      clr_cnt_r  <= clr_cnt_nx;
`endif
    end
  end

endmodule

// File: tb/tb_text_console_writer.sv
// Randomized self-checking bench for text_console_writer against a row/col reference model
// with a queue of expected RAM writes. Honors LINE_CLEAR_EN the same way as the design.
module tb_text_console_writer;

  logic        clk25mhz = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_emph = 1'b0;
  logic        in_ready, wr_en, busy;
  logic [11:0] wr_addr, cursor_addr;
  logic [7:0]  wr_data;

  text_console_writer dut (
    .clk25mhz(clk25mhz), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_emph(in_emph), .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .cursor_addr(cursor_addr), .busy(busy)
  );

  always #20 clk25mhz = ~clk25mhz;

  logic [19:0] exp_q[$];
  int row = 0;
  int col = 0;
  bit exp_busy = 1'b1;
  int n_checks = 0;
  int n_pass = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic int exp_cursor();
    return row * 80 + col;
  endfunction

  function automatic void push_blank(input int a);
    exp_q.push_back({a[11:0], 8'h20});
  endfunction

  function automatic void full_clear();
    for (int i = 0; i < 2720; i++) push_blank(i);
    exp_busy = 1'b1;
  endfunction

  function automatic void advance_row();
    col = 0;
    row = (row == 33) ? 0 : row + 1;
`ifdef LINE_CLEAR_EN
    for (int i = 0; i < 80; i++) push_blank(row * 80 + i);
    exp_busy = 1'b1;
`endif
  endfunction

  function automatic void model_byte(input logic [7:0] b, input logic e);
    int nc;
    if (b >= 8'h20 && b <= 8'h7E) begin
      exp_q.push_back({12'(exp_cursor()), e, b[6:0]});
      if (col == 79) advance_row();
      else col++;
    end else if (b == 8'h0A) begin
      advance_row();
    end else if (b == 8'h0D) begin
      col = 0;
    end else if (b == 8'h08) begin
      if (col > 0) begin
        col--;
        push_blank(exp_cursor());
      end
    end else if (b == 8'h09) begin
      nc = (col / 8 + 1) * 8;
      if (nc >= 80) advance_row();
      else col = nc;
    end else if (b == 8'h0C) begin
      row = 0;
      col = 0;
      full_clear();
    end
  endfunction

  // Every observed RAM write must be the next one the model predicts.
  always @(negedge clk25mhz) begin
    if (!reset && wr_en) begin
      if (exp_q.size() == 0) check_val("wr_unexpected", {wr_addr, wr_data}, 32'hFFFFFFFF);
      else check_val("wr", {wr_addr, wr_data}, {12'd0, exp_q.pop_front()});
    end
  end

  task automatic tick();
    @(posedge clk25mhz);
    #1;
  endtask

  task automatic wait_ready(input int limit);
    int n;
    n = 0;
    while (!in_ready && n < limit) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      tick();
      n++;
    end
    in_valid = 1'b0;
    check_val("ready_wait", {31'd0, in_ready}, 32'd1);
    exp_busy = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic e);
    wait_ready(4000);
    in_valid = 1'b1;
    in_data  = b;
    in_emph  = e;
    model_byte(b, e);
    tick();
    in_valid = 1'b0;
    check_val("cursor", {20'd0, cursor_addr}, exp_cursor());
    check_val("busy", {31'd0, busy}, {31'd0, exp_busy});
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 4000) begin
      @(negedge clk25mhz);
      n++;
    end
    check_val(tag, exp_q.size(), 32'd0);
  endtask

  task automatic goto_cell(input int tr, input int tc);
    int guard;
    guard = 0;
    send(8'h0D, 1'b0);
    while (row != tr && guard < 40) begin
      send(8'h0A, 1'b0);
      guard++;
    end
    while (col < tc) send(8'($urandom_range(8'h21, 8'h7E)), 1'($urandom));
  endtask

  initial begin
    int k;
    logic [7:0] b;
    reset = 1'b1;
    tick();
    tick();
    check_val("rst_wr_en", {31'd0, wr_en}, 32'd0);
    check_val("rst_wr_addr", {20'd0, wr_addr}, 32'd0);
    check_val("rst_wr_data", {24'd0, wr_data}, 32'h20);
    check_val("rst_cursor", {20'd0, cursor_addr}, 32'd0);
    check_val("rst_ready", {31'd0, in_ready}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    row = 0;
    col = 0;
    full_clear();
    wait_ready(3000);
    check_val("clr_cursor", {20'd0, cursor_addr}, 32'd0);
    drain("reset_clear_done");

    send(8'h41, 1'b1);
    send(8'h0D, 1'b0);
    for (int i = 0; i < 5; i++) send(8'h61 + 8'(i), 1'b0);
    send(8'h0A, 1'b0);
    send(8'h0D, 1'b0);
    send(8'h42, 1'b0);
    send(8'h0D, 1'b0);
    send(8'h08, 1'b0);
    send(8'h0A, 1'b0);
    for (int i = 0; i < 3; i++) send(8'h30 + 8'(i), 1'b0);
    send(8'h08, 1'b0);
    drain("directed_done");

    for (int i = 0; i < 400; i++) begin
      k = $urandom_range(0, 9);
      case (k)
        0: b = 8'h0A;
        1: b = 8'h0D;
        2: b = 8'h08;
        3: b = 8'h09;
        4: begin
          b = 8'($urandom);
          if (b == 8'h0C) b = 8'h7F;
        end
        default: b = 8'($urandom_range(8'h20, 8'h7E));
      endcase
      send(b, 1'($urandom));
    end
    drain("random_done");

    goto_cell(33, 79);
    send(8'h5A, 1'b0);
    drain("wrap_done");

    goto_cell(6, 20);
    send(8'h0C, 1'b0);
    drain("ff_clear_done");

    send(8'h0C, 1'b0);
    k = 0;
    @(negedge clk25mhz);
    while (!(wr_en && wr_addr == 12'd1000) && k < 3000) begin
      @(negedge clk25mhz);
      k++;
    end
    check_val("reached_1000", {20'd0, wr_addr}, 32'd1000);
    #1;
    reset = 1'b1;
    exp_q.delete();
    tick();
    tick();
    check_val("midrst_ready", {31'd0, in_ready}, 32'd0);
    check_val("midrst_wr_en", {31'd0, wr_en}, 32'd0);
    reset = 1'b0;
    row = 0;
    col = 0;
    full_clear();
    wait_ready(3000);
    drain("restart_clear_done");
    send(8'h43, 1'b1);
    drain("final_done");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
